// File: rtl/median_window_10.sv
// 10-deep sliding window feeding a median sorter; windows emit 1 cycle after the emitting accept, held until consumed (in_ready low while held).
// Optional MEDIAN_WINDOW_STATS_EN adds a 16-bit wrapping count of consumed windows.
module median_window_10 #(
  parameter int STRIDE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_0,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [31:0] data_3,
  output logic [31:0] data_4,
  output logic [31:0] data_5,
  output logic [31:0] data_6,
  output logic [31:0] data_7,
  output logic [31:0] data_8,
  output logic [31:0] data_9,
  output logic [3:0]  fill_level
`ifdef MEDIAN_WINDOW_STATS_EN
  ,
  output logic [15:0] window_count
`endif
);

  typedef enum logic {FILLING, STREAMING} state_t;

  localparam logic [3:0] STRIDE_M1 = 4'(STRIDE - 1);

  state_t      state_q, state_d;
  logic [3:0]  fill_q, fill_d;
  logic [3:0]  stride_q, stride_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] data_q [10];
  logic [31:0] data_d [10];
  logic        accept;
  logic        emit;
`ifdef MEDIAN_WINDOW_STATS_EN
  logic [15:0] window_count_q, window_count_d;
`endif

  always_comb begin
    in_ready    = !flush && !(out_valid_q && !out_ready);
    accept      = in_valid && in_ready;
    emit        = 1'b0;
    state_d     = state_q;
    fill_d      = fill_q;
    stride_d    = stride_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    if (flush) begin
      state_d     = FILLING;
      fill_d      = 4'd0;
      stride_d    = 4'd0;
      out_valid_d = 1'b0;
      for (int i = 0; i < 10; i++) data_d[i] = 32'd0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        for (int i = 0; i < 9; i++) data_d[i] = data_q[i+1];
        data_d[9] = in_data;
        if (fill_q != 4'd10) fill_d = fill_q + 4'd1;
        if (state_q == FILLING) begin
          if (fill_q == 4'd9) begin
            state_d = STREAMING;
            emit    = 1'b1;
          end
        end else if (stride_q == STRIDE_M1) begin
          emit = 1'b1;
        end else begin
          stride_d = stride_q + 4'd1;
        end
        // Consume and emit in the same cycle keeps out_valid high with the new window.
        if (emit) begin
          stride_d    = 4'd0;
          out_valid_d = 1'b1;
        end
      end
    end
  end

`ifdef MEDIAN_WINDOW_STATS_EN
  always_comb begin
    window_count_d = window_count_q;
    if (out_valid_q && out_ready) window_count_d = window_count_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILLING;
      fill_q      <= 4'd0;
      stride_q    <= 4'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 10; i++) data_q[i] <= 32'd0;
`ifdef MEDIAN_WINDOW_STATS_EN
      window_count_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
`ifdef MEDIAN_WINDOW_STATS_EN
      window_count_q <= window_count_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign fill_level = fill_q;
  assign data_0 = data_q[0];
  assign data_1 = data_q[1];
  assign data_2 = data_q[2];
  assign data_3 = data_q[3];
  assign data_4 = data_q[4];
  assign data_5 = data_q[5];
  assign data_6 = data_q[6];
  assign data_7 = data_q[7];
  assign data_8 = data_q[8];
  assign data_9 = data_q[9];
`ifdef MEDIAN_WINDOW_STATS_EN
  assign window_count = window_count_q;
`endif

endmodule

// File: tb/tb_median_window_10.sv
// Scoreboard bench for median_window_10: stimulus pushes expected windows, a monitor pops them on handshakes.
module tb_median_window_10;

  localparam int STRIDE = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_0, data_1, data_2, data_3, data_4;
  logic [31:0] data_5, data_6, data_7, data_8, data_9;
  logic [3:0]  fill_level;
`ifdef MEDIAN_WINDOW_STATS_EN
  logic [15:0] window_count;
  int          wc_model;
`endif

  median_window_10 #(.STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3), .data_4(data_4),
    .data_5(data_5), .data_6(data_6), .data_7(data_7), .data_8(data_8), .data_9(data_9),
    .fill_level(fill_level)
`ifdef MEDIAN_WINDOW_STATS_EN
    , .window_count(window_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0][31:0] dut_win;
  assign dut_win[0] = data_0;
  assign dut_win[1] = data_1;
  assign dut_win[2] = data_2;
  assign dut_win[3] = data_3;
  assign dut_win[4] = data_4;
  assign dut_win[5] = data_5;
  assign dut_win[6] = data_6;
  assign dut_win[7] = data_7;
  assign dut_win[8] = data_8;
  assign dut_win[9] = data_9;

  int total = 0;
  int bad   = 0;
  bit known = 1'b0;
  bit mvalid = 1'b0;
  logic [31:0]      hist[$];
  logic [9:0][31:0] exp_q[$];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window is the last ten samples since flush/reset, zero-padded on the oldest side.
  function automatic logic [9:0][31:0] model_win();
    logic [9:0][31:0] w;
    for (int i = 0; i < 10; i++) begin
      int idx;
      idx = hist.size() - 10 + i;
      w[i] = (idx >= 0) ? hist[idx] : 32'd0;
    end
    return w;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic f,
                      input logic r, input logic ordy);
    logic exp_rdy;
    logic acc;
    int   n;
    in_valid = v; in_data = d; flush = f; rst = r; out_ready = ordy;
    @(negedge clk);
    exp_rdy = !f && !(mvalid && !ordy);
    if (known) begin
      if (!r) chk("in_ready", 320'(in_ready), 320'(exp_rdy));
      chk("fill_level", 320'(fill_level), 320'((hist.size() > 10) ? 10 : hist.size()));
      chk("data_window", dut_win, model_win());
    end
    acc = v && exp_rdy && !r;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      exp_q.delete();
      mvalid = 1'b0;
      known  = 1'b1;
    end else if (f) begin
      if (mvalid && !ordy && exp_q.size() != 0) void'(exp_q.pop_front());
      hist.delete();
      mvalid = 1'b0;
    end else begin
      if (mvalid && ordy) mvalid = 1'b0;
      if (acc) begin
        hist.push_back(d);
        n = hist.size();
        if (n == 10 || (n > 10 && (n - 10) % STRIDE == 0)) begin
          exp_q.push_back(model_win());
          mvalid = 1'b1;
        end
      end
    end
  endtask

  // Monitor: every cycle out_valid must match a pending window; handshakes retire it.
  initial begin
`ifdef MEDIAN_WINDOW_STATS_EN
    wc_model = 0;
`endif
    forever begin
      @(negedge clk);
      if (known) begin
        chk("out_valid", 320'(out_valid), 320'(exp_q.size() != 0));
`ifdef MEDIAN_WINDOW_STATS_EN
        chk("window_count", 320'(window_count), 320'(wc_model));
        if (rst) wc_model = 0;
        else if (out_valid && out_ready) wc_model = (wc_model + 1) % 65536;
`endif
        if (out_valid && exp_q.size() != 0) begin
          chk("out_window", dut_win, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_data = '0; flush = 1'b0; rst = 1'b1; out_ready = 1'b1;
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    for (int k = 1; k <= 16; k++) step(1'b1, 32'(k), 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) step(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd11, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) step(1'b1, 32'(k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'd99, 1'b1, 1'b0, 1'b1);
    for (int k = 20; k <= 29; k++) step(1'b1, 32'(k), 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    for (int k = 1; k <= 10; k++) step(1'b1, 32'(k + 40), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) step(1'b1, 32'(k + 50), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (5) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median_window_10.md
MEDIAN_WINDOW_10 -- requirements
Module: median_window_10

Interface
REQ-001 The block SHALL have one parameter: STRIDE, default 1, meaning the number of accepted samples between emitted windows once the window is full (legal range 1..10).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream sample valid.
REQ-005 Port: in_ready  output  1  block can accept a sample this cycle.
REQ-006 Port: in_data  input  32  unsigned sample.
REQ-007 Port: flush  input  1  synchronous window discard.
REQ-008 Port: out_valid  output  1  window on data_0..data_9 is valid.
REQ-009 Port: out_ready  input  1  downstream sorter/median stage consumes the window.
REQ-010 Port: data_0 .. data_9  output  32 each  window, data_0 oldest, data_9 newest, wired directly to the sorting-network inputs.
REQ-011 Port: fill_level  output  4  number of valid samples held, 0..10.

Function
REQ-012 Accept SHALL occur when in_valid && in_ready; in_ready SHALL be !flush && !(out_valid && !out_ready).
REQ-013 On accept, the window SHALL shift: data_i <= data_(i+1) for i=0..8, data_9 <= in_data.
REQ-014 fill_level SHALL increment on accept and saturate at 10.
REQ-015 State FILLING (fill_level<10) SHALL move to STREAMING on the accept that makes fill_level 10; STREAMING SHALL return to FILLING only on flush or rst.
REQ-016 The 10th accepted sample SHALL emit the first window; in STREAMING a window SHALL be emitted every STRIDE accepts, counted by a stride counter reset to 0 on each emission.
REQ-017 Latency: out_valid SHALL rise the cycle after the emitting accept, with data_0..data_9 already holding the new window.
REQ-018 out_valid SHALL remain high, with data_0..data_9 stable, until out_valid && out_ready.
REQ-019 Simultaneous consume and emitting accept: out_valid SHALL stay 1 and present the new window next cycle; consume without emitting accept SHALL clear out_valid.
REQ-020 Non-emitting accepts while out_valid=0 SHALL shift data_0..data_9 with out_valid low.
REQ-021 flush SHALL clear fill_level, the stride counter and out_valid, return to FILLING, and zero data_0..data_9 next cycle; in_valid in the same cycle SHALL be dropped.
REQ-022 flush asserted while out_valid=1 and not consumed SHALL discard that window.
REQ-023 No sample SHALL be lost or duplicated while in_ready and out_ready toggle arbitrarily.

Reset
REQ-024 On rst the block SHALL set data_0..data_9=0, fill_level=0, out_valid=0, the stride counter to 0 and the state to FILLING; in_ready SHALL read 1 the cycle after reset deasserts.
REQ-025 rst SHALL take priority over flush and over any handshake in the same cycle.

Configuration
REQ-026 Macro MEDIAN_WINDOW_STATS_EN, when defined, SHALL add output port window_count (16 bits), reset to 0, incremented on each out_valid && out_ready, wrapping 0xFFFF->0, and unaffected by flush.
REQ-027 Without MEDIAN_WINDOW_STATS_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 STRIDE=1, out_ready=1, samples 1..12 each cycle -> first out_valid the cycle after sample 10 with data_0..9=1..10; next two windows 2..11 and 3..12.
REQ-029 STRIDE=3, samples 1..16 continuous -> windows 1..10, 4..13 and 7..16 only; out_valid low otherwise.
REQ-030 Window 1..10 held with out_ready=0 for 5 cycles -> in_ready=0, data stable, sample 11 not accepted until the consume cycle.
REQ-031 Samples 1..7 then flush with in_valid=1 and in_data=99 -> fill_level=0, 99 dropped; 10 further samples 20..29 -> window 20..29.
REQ-032 rst asserted during STREAMING with out_valid=1 -> next cycle out_valid=0, fill_level=0, all data_i=0.
REQ-033 With MEDIAN_WINDOW_STATS_EN, 65537 consumed windows -> window_count=1; after a flush window_count is unchanged.
